kamikaze_imem: RTL and testbench
================================

Name: kamikaze_imem

Overview:
- Instruction-memory responder on the far side of the core's fetch port.
- The core drives a byte address on im_addr_i. This block returns the addressed 32-bit word on im_data_o with one-cycle registered latency.
- It also contains a byte-stream program loader with a valid/ready handshake. The loader fills the array at boot and holds the core in reset while loading.
- Sits beside the kamikaze core top; im_addr_i/im_data_o connect directly to the core's im_addr_o/im_data_i.

Parameters:
- ADDR_WIDTH, 10, word-address bits; depth = 2**ADDR_WIDTH words (default 4 KiB).
- NOP_INSTR, 32'h00000013, word returned when a fetch is blocked or out of range (addi x0,x0,0).

Ports:
- clk_i  input  1  single clock, all logic on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- im_addr_i  input  32  fetch byte address from core.
- im_data_o  output  32  fetched instruction word, registered.
- ld_en_i  input  1  level; high = loader mode requested.
- ld_valid_i  input  1  loader byte valid.
- ld_data_i  input  8  loader byte.
- ld_ready_o  output  1  loader can accept a byte this cycle.
- ld_count_o  output  ADDR_WIDTH+1  complete words written since the last loader entry.
- core_rst_o  output  1  active-low reset to the core; low = core held.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=RUN, im_data_o=NOP_INSTR, ld_ready_o=0, ld_count_o=0, core_rst_o=0.
  - Byte counter and write pointer are cleared.
  - Array contents are not reset.
- States:
  - RUN -> LOAD when ld_en_i=1.
  - LOAD -> WRITE when the 4th byte of a word is accepted.
  - WRITE -> LOAD after one cycle if ld_en_i=1, else -> RUN.
  - LOAD -> RUN when ld_en_i=0.
- Entry into LOAD from RUN:
  - Write pointer and byte counter cleared to 0.
  - ld_count_o cleared to 0.
- ld_ready_o:
  - Equals 1 only in LOAD (registered state decode).
  - A byte is accepted on a cycle with ld_valid_i & ld_ready_o.
  - ld_valid_i is ignored in RUN and WRITE.
- Byte assembly:
  - Little-endian; byte k of a word goes to bits [8k+7:8k], k = 0..3.
- WRITE cycle:
  - Assembled word written to mem[ptr].
  - ptr increments, wrapping from 2**ADDR_WIDTH-1 to 0.
  - ld_count_o increments, saturating at 2**ADDR_WIDTH.
  - ld_ready_o=0 during WRITE; a byte offered that cycle is not accepted and must be held by the source.
- ld_en_i falling mid-word (byte counter 1..3):
  - Partial bytes are discarded; no write occurs.
  - Byte counter cleared; ld_count_o holds its value.
- ld_en_i falling during WRITE: the write still completes, then -> RUN.
- core_rst_o:
  - Registered; 1 only when state=RUN and ld_en_i was 0 on the previous edge.
  - First release occurs on the 2nd rising edge after rst_i deasserts with ld_en_i=0.
  - Drops to 0 on the edge that enters LOAD.
- Fetch, every cycle in RUN:
  - im_data_o <= mem[im_addr_i[ADDR_WIDTH+1:2]] if im_addr_i[31:ADDR_WIDTH+2]==0, else NOP_INSTR.
  - im_addr_i[1:0] is ignored (word-aligned fetch).
  - Latency: address at edge n -> data valid after edge n+1.
- Fetch in LOAD or WRITE: im_data_o <= NOP_INSTR; no array read.
- Read-during-write hazard cannot occur, since fetch is disabled outside RUN.
- Array: single-port, inferable as block RAM; one write port, one read port, never both active in the same cycle.

Test Plan:
- Reset with ld_en_i=0 -> im_data_o=32'h00000013, ld_ready_o=0, ld_count_o=0, core_rst_o=0; core_rst_o=1 by 2nd edge after release.
- ld_en_i=1, stream bytes 93,00,10,00,13,01,20,00 (hex) -> mem[0]=32'h00100093, mem[1]=32'h00200113, ld_count_o=2, core_rst_o=0 throughout, ld_ready_o=0 on each WRITE cycle.
- After that load, ld_en_i=0, im_addr_i=0x4 then 0x6 -> im_data_o=32'h00200113 one cycle later in both cases.
- im_addr_i=0x00001000 (ADDR_WIDTH=10) -> im_data_o=32'h00000013; im_addr_i=0xFFFFFFFC -> 32'h00000013.
- Load 3 bytes then drop ld_en_i -> no array write, ld_count_o unchanged, state RUN, previous mem[ptr] content returned on fetch.
- Load 2**ADDR_WIDTH+1 words -> pointer wraps, last word overwrites mem[0], ld_count_o saturates at 1024.
- Assert rst_i low mid-LOAD with 2 bytes pending -> outputs immediately at reset values; no write on release; re-entering LOAD starts at ptr 0.

Source files
------------

// File: rtl/kamikaze_imem.sv
// Instruction memory for the kamikaze core: registered word fetch plus a
// byte-stream boot loader that holds the core in reset while it fills the array.
module kamikaze_imem #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           im_addr_i,
    output logic [31:0]           im_data_o,
    input  logic                  ld_en_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_data_i,
    output logic                  ld_ready_o,
    output logic [ADDR_WIDTH:0]   ld_count_o,
    output logic                  core_rst_o
);

    localparam int unsigned        DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        S_RUN,
        S_LOAD,
        S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            byte_cnt_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [31:0]           wbuf_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  ld_en_q;
    logic                  core_rst_q;
    logic                  rd_en;
    logic                  rd_hit_q;
    logic [31:0]           rd_word_q;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  unused_addr_bits;

    logic [31:0] mem [DEPTH];

    assign ld_ready_o = (state_q == S_LOAD);
    assign ld_count_o = count_q;
    assign core_rst_o = core_rst_q;

    assign rd_idx           = im_addr_i[ADDR_WIDTH+1:2];
    assign rd_en            = (state_q == S_RUN) && (im_addr_i[31:ADDR_WIDTH+2] == '0);
    assign unused_addr_bits = ^im_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (ld_en_i) state_d = S_LOAD;
            S_LOAD: begin
                if (!ld_en_i)
                    state_d = S_RUN;
                else if (ld_valid_i && byte_cnt_q == 2'd3)
                    state_d = S_WRITE;
            end
            S_WRITE: state_d = ld_en_i ? S_LOAD : S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    // ld_en_q resets high so the core stays held for two edges after reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_RUN;
            byte_cnt_q <= '0;
            ptr_q      <= '0;
            wbuf_q     <= '0;
            count_q    <= '0;
            ld_en_q    <= 1'b1;
            core_rst_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_en_q    <= ld_en_i;
            core_rst_q <= (state_d == S_RUN) && !ld_en_q;
            rd_hit_q   <= rd_en;
            case (state_q)
                S_RUN: begin
                    if (ld_en_i) begin
                        ptr_q      <= '0;
                        byte_cnt_q <= '0;
                        count_q    <= '0;
                    end
                end
                S_LOAD: begin
                    if (!ld_en_i) begin
                        byte_cnt_q <= '0;
                    end else if (ld_valid_i) begin
                        wbuf_q[{byte_cnt_q, 3'b000} +: 8] <= ld_data_i;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                    end
                end
                S_WRITE: begin
                    ptr_q <= ptr_q + 1'b1;
                    if (count_q != COUNT_MAX)
                        count_q <= count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Array kept reset-free for RAM inference; the NOP substitution lives on
    // the output mux, qualified by the resettable rd_hit_q flag.
    always_ff @(posedge clk_i) begin
        if (state_q == S_WRITE)
            mem[ptr_q] <= wbuf_q;
        else if (rd_en)
            rd_word_q <= mem[rd_idx];
    end

    assign im_data_o = rd_hit_q ? rd_word_q : NOP_INSTR;

endmodule

// File: tb/tb_kamikaze_imem.sv
// Directed self-checking bench for kamikaze_imem: reset, load, fetch, range,
// partial-word abort, pointer wrap/saturation and reset during load.
module tb_kamikaze_imem;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] im_addr_i = '0;
    logic [31:0] im_data_o;
    logic        ld_en_i = 1'b0;
    logic        ld_valid_i = 1'b0;
    logic [7:0]  ld_data_i = '0;
    logic        ld_ready_o;
    logic [10:0] ld_count_o;
    logic        core_rst_o;

    int n_cmp = 0;
    int n_bad = 0;

    kamikaze_imem #(.ADDR_WIDTH(10), .NOP_INSTR(32'h0000_0013)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .im_addr_i  (im_addr_i),
        .im_data_o  (im_data_o),
        .ld_en_i    (ld_en_i),
        .ld_valid_i (ld_valid_i),
        .ld_data_i  (ld_data_i),
        .ld_ready_o (ld_ready_o),
        .ld_count_o (ld_count_o),
        .core_rst_o (core_rst_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the byte was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ld_data_i  = b;
        ld_valid_i = 1'b1;
        while (!ld_ready_o && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        if (!ld_ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ld_ready_o=%0b expected 1 within 8 cycles", ld_ready_o);
        end
        @(negedge clk_i);
        ld_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit chk);
        for (int k = 0; k < 4; k++) send_byte(w[k*8 +: 8]);
        if (chk) begin
            n_cmp++;
            if (ld_ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL write_ready: got %0b expected 0", ld_ready_o);
            end
            n_cmp++;
            if (core_rst_o !== 1'b0) begin
                n_bad++;
                $display("FAIL load_core_rst: got %0b expected 0", core_rst_o);
            end
        end
    endtask

    task automatic enter_load();
        @(negedge clk_i);
        ld_en_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic leave_load();
        ld_en_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string nm);
        @(negedge clk_i);
        im_addr_i = a;
        @(posedge clk_i);
        #1;
        n_cmp++;
        if (im_data_o !== exp) begin
            n_bad++;
            $display("FAIL %s: addr=%h got %h expected %h", nm, a, im_data_o, exp);
        end
    endtask

    task automatic test_reset();
        rst_i   = 1'b0;
        ld_en_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++; if (im_data_o !== NOP) begin n_bad++; $display("FAIL rst_data: got %h expected %h", im_data_o, NOP); end
        n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %0b expected 0", ld_ready_o); end
        n_cmp++; if (ld_count_o !== 11'd0) begin n_bad++; $display("FAIL rst_count: got %0d expected 0", ld_count_o); end
        n_cmp++; if (core_rst_o !== 1'b0) begin n_bad++; $display("FAIL rst_core: got %0b expected 0", core_rst_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        n_cmp++; if (core_rst_o !== 1'b0) begin n_bad++; $display("FAIL core_rst_edge1: got %0b expected 0", core_rst_o); end
        @(posedge clk_i);
        #1;
        n_cmp++; if (core_rst_o !== 1'b1) begin n_bad++; $display("FAIL core_rst_edge2: got %0b expected 1", core_rst_o); end
    endtask

    task automatic test_load_basic();
        enter_load();
        n_cmp++; if (core_rst_o !== 1'b0) begin n_bad++; $display("FAIL enter_core_rst: got %0b expected 0", core_rst_o); end
        n_cmp++; if (ld_ready_o !== 1'b1) begin n_bad++; $display("FAIL load_ready: got %0b expected 1", ld_ready_o); end
        send_word(32'h0010_0093, 1'b1);
        send_word(32'h0020_0113, 1'b1);
        leave_load();
        n_cmp++; if (ld_count_o !== 11'd2) begin n_bad++; $display("FAIL basic_count: got %0d expected 2", ld_count_o); end
    endtask

    task automatic test_fetch();
        fetch(32'h0000_0004, 32'h0020_0113, "fetch_4");
        fetch(32'h0000_0006, 32'h0020_0113, "fetch_6");
        fetch(32'h0000_0000, 32'h0010_0093, "fetch_0");
        n_cmp++; if (core_rst_o !== 1'b1) begin n_bad++; $display("FAIL run_core_rst: got %0b expected 1", core_rst_o); end
    endtask

    task automatic test_out_of_range();
        fetch(32'h0000_1000, NOP, "oor_1000");
        fetch(32'h0000_0004, 32'h0020_0113, "fetch_4b");
        fetch(32'hFFFF_FFFC, NOP, "oor_fffc");
    endtask

    task automatic test_partial();
        enter_load();
        send_word(32'h0010_0093, 1'b0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        ld_en_i = 1'b0;
        @(negedge clk_i);
        n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL partial_ready: got %0b expected 0", ld_ready_o); end
        n_cmp++; if (ld_count_o !== 11'd1) begin n_bad++; $display("FAIL partial_count: got %0d expected 1", ld_count_o); end
        @(negedge clk_i);
        fetch(32'h0000_0004, 32'h0020_0113, "partial_nowrite");
        fetch(32'h0000_0000, 32'h0010_0093, "partial_word0");
    endtask

    task automatic test_wrap();
        enter_load();
        for (int i = 0; i <= 1024; i++) send_word(32'hC0DE_0000 | 32'(i), 1'b0);
        leave_load();
        n_cmp++; if (ld_count_o !== 11'd1024) begin n_bad++; $display("FAIL wrap_count: got %0d expected 1024", ld_count_o); end
        fetch(32'h0000_0000, 32'hC0DE_0400, "wrap_word0");
        fetch(32'h0000_0004, 32'hC0DE_0001, "wrap_word1");
        fetch(32'h0000_0FFC, 32'hC0DE_03FF, "wrap_word1023");
    endtask

    task automatic test_reset_mid_load();
        enter_load();
        send_word(32'hDEAD_BEEF, 1'b0);
        send_byte(8'h11);
        send_byte(8'h22);
        rst_i = 1'b0;
        #1;
        n_cmp++; if (ld_ready_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %0b expected 0", ld_ready_o); end
        n_cmp++; if (ld_count_o !== 11'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d expected 0", ld_count_o); end
        n_cmp++; if (core_rst_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_core: got %0b expected 0", core_rst_o); end
        n_cmp++; if (im_data_o !== NOP) begin n_bad++; $display("FAIL mid_rst_data: got %h expected %h", im_data_o, NOP); end
        ld_en_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        fetch(32'h0000_0004, 32'hC0DE_0001, "mid_rst_nowrite");
        fetch(32'h0000_0000, 32'hDEAD_BEEF, "mid_rst_word0");
        enter_load();
        send_word(32'h1234_5678, 1'b0);
        leave_load();
        n_cmp++; if (ld_count_o !== 11'd1) begin n_bad++; $display("FAIL reload_count: got %0d expected 1", ld_count_o); end
        fetch(32'h0000_0000, 32'h1234_5678, "reload_word0");
        fetch(32'h0000_0004, 32'hC0DE_0001, "reload_word1");
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_fetch();
        test_out_of_range();
        test_partial();
        test_wrap();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
